// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter: writeback stage feeding the 16x32 register file.
//
// Merges single-cycle ALU results with in-order load responses onto the single
// register-file write port. Load responses are buffered in a small FIFO. The
// ALU has priority unless the FIFO head has lost arbitration STARVE_MAX times
// in a row. A write to r15 is turned into a PC redirect. Otherwise r15 gets
// the sequential (or held) PC. A per-register pending-load scoreboard (busy)
// lets decode detect RAW hazards on outstanding loads.
//
// Optional feature, enabled with macro WB_BYPASS_EN:
//   Adds a two-port write-to-read bypass for decode operand reads.
//   Without it, decode must stall one cycle after a write to a source register.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int          FIFO_DEPTH = 4,   // power of 2, >= 2
    parameter int          STARVE_MAX = 3,
    parameter int unsigned PC_INC     = 4
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    // ALU result
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_addr,
    input  logic [31:0] alu_data,
    // load issue (scoreboard set)
    input  logic        ld_issue,
    input  logic [3:0]  ld_issue_addr,
    // load response
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_addr,
    input  logic [31:0] ld_data,
    // program counter
    input  logic [31:0] pc_cur,
    input  logic        pc_stall,
    // register file write port
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] wr_pc,
    output logic        pc_redirect,
    output logic [15:0] busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [3:0]  rf_rd_addr1,
    input  logic [3:0]  rf_rd_addr2,
    input  logic [31:0] rf_rd_data1,
    input  logic [31:0] rf_rd_data2,
    output logic [31:0] op_data1,
    output logic [31:0] op_data2
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [31:0]      PC_STEP    = 32'(PC_INC);
    localparam logic [3:0]       PC_REG     = 4'd15;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    // State
    wb_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [15:0]      busy_q,   busy_d;

    // Arbitration signals
    logic      fifo_empty, fifo_full, starve_hit;
    logic      alu_go, alu_take, push, pop, wb_valid, is_pc;
    wb_entry_t head, sel;

    // Arbitration: ALU first, unless the FIFO head has starved long enough.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        starve_hit = (starve_q == STARVE_TOP);
        alu_go     = !(starve_hit && !fifo_empty);
        alu_take   = alu_valid && alu_go;
        pop        = !alu_take && !fifo_empty;
        // Ready depends on the registered count only, so a full FIFO that
        // pops this cycle still refuses a push.
        push       = ld_valid && !fifo_full;
        head       = mem_q[rd_ptr_q];
        sel        = alu_take ? wb_entry_t'{addr: alu_addr, data: alu_data} : head;
        wb_valid   = alu_take || pop;
        is_pc      = (sel.addr == PC_REG);
    end

    // Writeback decode and PC generation; everything forced idle in reset.
    always_comb begin
        alu_ready   = rst && alu_go;
        ld_ready    = rst && !fifo_full;
        wr_en       = rst && wb_valid && !is_pc;
        pc_redirect = rst && wb_valid && is_pc;
        wr_addr     = sel.addr;
        wr_data     = sel.data;
        if (!rst)
            wr_pc = '0;
        else if (wb_valid && is_pc)
            wr_pc = sel.data;
        else if (pc_stall)
            wr_pc = pc_cur;
        else
            wr_pc = pc_cur + PC_STEP;
        busy = busy_q;
    end

    // Next-state for pointers, occupancy, starve counter and scoreboard.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        starve_d = starve_q;
        busy_d   = busy_q;

        if (fifo_empty || pop)
            starve_d = '0;
        else if (!starve_hit)
            starve_d = starve_q + SW'(1);

        // Clear before set so an issue in the pop cycle keeps the bit.
        if (pop)
            busy_d[head.addr] = 1'b0;
        if (ld_issue)
            busy_d[ld_issue_addr] = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count qualifies every entry.
        if (push)
            mem_q[wr_ptr_q] <= wb_entry_t'{addr: ld_addr, data: ld_data};
    end

`ifdef WB_BYPASS_EN
    // Forward the write in flight to decode operand reads.
    always_comb begin
        op_data1 = (wr_en && wr_addr == rf_rd_addr1) ? wr_data : rf_rd_data1;
        op_data2 = (wr_en && wr_addr == rf_rd_addr2) ? wr_data : rf_rd_data2;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter: directed bench for wb_arbiter. A vector table covers PC and
// ALU writeback decode; hand sequences cover loads, starvation, FIFO full,
// set-wins scoreboard and mid-operation reset.
// Inputs change on the falling edge; outputs are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [3:0]  ld_issue_addr;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] pc_cur;
    logic        pc_stall;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic        pc_redirect;
    logic [15:0] busy;
`ifdef WB_BYPASS_EN
    logic [3:0]  rf_rd_addr1, rf_rd_addr2;
    logic [31:0] rf_rd_data1, rf_rd_data2, op_data1, op_data2;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .ld_issue      (ld_issue),
        .ld_issue_addr (ld_issue_addr),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .pc_cur        (pc_cur),
        .pc_stall      (pc_stall),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_pc         (wr_pc),
        .pc_redirect   (pc_redirect),
        .busy          (busy)
`ifdef WB_BYPASS_EN
        ,
        .rf_rd_addr1   (rf_rd_addr1),
        .rf_rd_addr2   (rf_rd_addr2),
        .rf_rd_data1   (rf_rd_data1),
        .rf_rd_data2   (rf_rd_data2),
        .op_data1      (op_data1),
        .op_data2      (op_data2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid     = 1'b0;
        alu_addr      = 4'd0;
        alu_data      = 32'd0;
        ld_issue      = 1'b0;
        ld_issue_addr = 4'd0;
        ld_valid      = 1'b0;
        ld_addr       = 4'd0;
        ld_data       = 32'd0;
        pc_cur        = 32'h100;
        pc_stall      = 1'b0;
`ifdef WB_BYPASS_EN
        rf_rd_addr1   = 4'd0;
        rf_rd_addr2   = 4'd0;
        rf_rd_data1   = 32'd0;
        rf_rd_data2   = 32'd0;
`endif
    endtask

    // Wait for the falling edge: the point where the next cycle's inputs are driven.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    typedef struct {
        logic        alu_valid;
        logic [3:0]  alu_addr;
        logic [31:0] alu_data;
        logic [31:0] pc_cur;
        logic        pc_stall;
        logic        exp_wr_en;
        logic        exp_redirect;
        logic [31:0] exp_wr_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 4'd0,  32'h0,        32'h100,      1'b0, 1'b0, 1'b0, 32'h104};
        vecs[1] = '{1'b0, 4'd0,  32'h0,        32'h100,      1'b1, 1'b0, 1'b0, 32'h100};
        vecs[2] = '{1'b0, 4'd0,  32'h0,        32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 4'd7,  32'h12345678, 32'h200,      1'b0, 1'b1, 1'b0, 32'h204};
        vecs[4] = '{1'b1, 4'd0,  32'hA5A5A5A5, 32'h300,      1'b1, 1'b1, 1'b0, 32'h300};
        vecs[5] = '{1'b1, 4'd14, 32'h0F0F0F0F, 32'h400,      1'b0, 1'b1, 1'b0, 32'h404};
        vecs[6] = '{1'b1, 4'd15, 32'h2000,     32'h100,      1'b0, 1'b0, 1'b1, 32'h2000};
        vecs[7] = '{1'b1, 4'd15, 32'h3000,     32'h100,      1'b1, 1'b0, 1'b1, 32'h3000};

        // ---------------- reset state ----------------
        idle();
        rst       = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 4'd2;
        #2;
        check("rst_wr_en",     32'(wr_en),       32'd0);
        check("rst_redirect",  32'(pc_redirect), 32'd0);
        check("rst_wr_pc",     wr_pc,            32'd0);
        check("rst_alu_ready", 32'(alu_ready),   32'd0);
        check("rst_ld_ready",  32'(ld_ready),    32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        next_cycle();
        idle();
        rst = 1'b1;

        // ---------------- vector table: PC and ALU decode ----------------
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            idle();
            alu_valid = vecs[i].alu_valid;
            alu_addr  = vecs[i].alu_addr;
            alu_data  = vecs[i].alu_data;
            pc_cur    = vecs[i].pc_cur;
            pc_stall  = vecs[i].pc_stall;
`ifdef WB_BYPASS_EN
            rf_rd_addr1 = vecs[i].alu_addr;
            rf_rd_data1 = 32'hCAFE0000;
            rf_rd_addr2 = vecs[i].alu_addr + 4'd1;
            rf_rd_data2 = 32'hCAFE0002;
`endif
            #2;
            check($sformatf("v%0d_wr_en", i),     32'(wr_en),       32'(vecs[i].exp_wr_en));
            check($sformatf("v%0d_redirect", i),  32'(pc_redirect), 32'(vecs[i].exp_redirect));
            check($sformatf("v%0d_wr_pc", i),     wr_pc,            vecs[i].exp_wr_pc);
            check($sformatf("v%0d_alu_ready", i), 32'(alu_ready),   32'd1);
            if (vecs[i].exp_wr_en) begin
                check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].alu_addr));
                check($sformatf("v%0d_wr_data", i), wr_data,      vecs[i].alu_data);
            end
`ifdef WB_BYPASS_EN
            check($sformatf("v%0d_op1", i), op_data1,
                  vecs[i].exp_wr_en ? vecs[i].alu_data : 32'hCAFE0000);
            check($sformatf("v%0d_op2", i), op_data2, 32'hCAFE0002);
`endif
        end

        // ---------------- load writeback and scoreboard ----------------
        next_cycle(); idle();
        ld_issue = 1'b1; ld_issue_addr = 4'd3;
        #2 check("ld_busy_before_issue", 32'(busy[3]), 32'd0);
        next_cycle(); idle();
        ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 32'hDEADBEEF;
        #2;
        check("ld_busy_after_issue", 32'(busy[3]), 32'd1);
        check("ld_no_bypass",        32'(wr_en),   32'd0);
        next_cycle(); idle();
        #2;
        check("ld_wr_en",      32'(wr_en),   32'd1);
        check("ld_wr_addr",    32'(wr_addr), 32'd3);
        check("ld_wr_data",    wr_data,      32'hDEADBEEF);
        check("ld_busy_held",  32'(busy[3]), 32'd1);
        next_cycle(); idle();
        #2;
        check("ld_busy_clear", 32'(busy[3]), 32'd0);
        check("ld_idle_wr_en", 32'(wr_en),   32'd0);

        // ---------------- starvation: ALU wins 3 times ----------------
        next_cycle(); idle();
        ld_issue = 1'b1; ld_issue_addr = 4'd4;
        next_cycle(); idle();
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
        ld_valid = 1'b1; ld_addr = 4'd4; ld_data = 32'h44444444;
        #2 check("st_push_alu", 32'(wr_addr), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            ld_valid = 1'b0;
            #2;
            check($sformatf("st_win%0d_ready", k), 32'(alu_ready), 32'd1);
            check($sformatf("st_win%0d_addr", k),  32'(wr_addr),   32'd1);
        end
        next_cycle();
        #2;
        check("st_block_ready", 32'(alu_ready), 32'd0);
        check("st_pop_wr_en",   32'(wr_en),     32'd1);
        check("st_pop_addr",    32'(wr_addr),   32'd4);
        check("st_pop_data",    wr_data,        32'h44444444);
        next_cycle();
        #2;
        check("st_after_ready", 32'(alu_ready), 32'd1);
        check("st_after_addr",  32'(wr_addr),   32'd1);
        check("st_busy_clear",  32'(busy[4]),   32'd0);

        // ---------------- FIFO full and in-order drain ----------------
        for (int i = 0; i < 4; i++) begin
            next_cycle(); idle();
            ld_issue = 1'b1; ld_issue_addr = 4'(8 + i);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle(); idle();
            alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
            ld_valid = 1'b1; ld_addr = 4'(8 + i); ld_data = 32'hD0 + 32'(i);
            #2 check($sformatf("fill%0d_ld_ready", i), 32'(ld_ready), 32'd1);
        end
        next_cycle();
        ld_addr = 4'd12; ld_data = 32'hBAD;
        #2;
        check("full_ld_ready",  32'(ld_ready),  32'd0);
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        check("full_pop_addr",  32'(wr_addr),   32'd8);
        check("full_pop_data",  wr_data,        32'hD0);
        for (int i = 1; i < 4; i++) begin
            next_cycle(); idle();
            #2;
            check($sformatf("drain%0d_ld_ready", i), 32'(ld_ready), 32'd1);
            check($sformatf("drain%0d_addr", i),     32'(wr_addr),  32'(8 + i));
            check($sformatf("drain%0d_data", i),     wr_data,       32'hD0 + 32'(i));
        end
        next_cycle(); idle();
        #2;
        check("drain_empty_wr_en", 32'(wr_en), 32'd0);
        check("drain_busy",        32'(busy),  32'd0);

        // ---------------- scoreboard: set wins over clear ----------------
        next_cycle(); idle();
        ld_issue = 1'b1; ld_issue_addr = 4'd6;
        next_cycle(); idle();
        ld_valid = 1'b1; ld_addr = 4'd6; ld_data = 32'h66;
        next_cycle(); idle();
        ld_issue = 1'b1; ld_issue_addr = 4'd6;
        #2 check("sw_pop_addr", 32'(wr_addr), 32'd6);
        next_cycle(); idle();
        ld_valid = 1'b1; ld_addr = 4'd6; ld_data = 32'h67;
        #2 check("sw_busy_kept", 32'(busy[6]), 32'd1);
        next_cycle(); idle();
        #2 check("sw_second_data", wr_data, 32'h67);
        next_cycle(); idle();
        #2 check("sw_busy_clear", 32'(busy), 32'd0);

        // ---------------- reset mid-operation ----------------
        next_cycle(); idle();
        ld_issue = 1'b1; ld_issue_addr = 4'd5;
        next_cycle(); idle();
        ld_issue = 1'b1; ld_issue_addr = 4'd6;
        next_cycle(); idle();
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
        ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'h55;
        next_cycle();
        ld_addr = 4'd6; ld_data = 32'h56;
        next_cycle();
        ld_valid = 1'b0;
        #2;
        check("mr_busy_before", 32'(busy),    32'h0060);
        check("mr_alu_wins",    32'(wr_addr), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mr_wr_en",     32'(wr_en),       32'd0);
        check("mr_busy",      32'(busy),        32'd0);
        check("mr_alu_ready", 32'(alu_ready),   32'd0);
        check("mr_ld_ready",  32'(ld_ready),    32'd0);
        check("mr_wr_pc",     wr_pc,            32'd0);
        check("mr_redirect",  32'(pc_redirect), 32'd0);
        next_cycle(); idle();
        rst = 1'b1;
        #2;
        check("mr_post_wr_en",     32'(wr_en),     32'd0);
        check("mr_post_ld_ready",  32'(ld_ready),  32'd1);
        check("mr_post_alu_ready", 32'(alu_ready), 32'd1);
        check("mr_post_busy",      32'(busy),      32'd0);
        next_cycle();
        #2 check("mr_post2_wr_en", 32'(wr_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
